// File: rtl/padlock_pkg.sv
// Shared types and helpers for the code padlock.
// Build option: PADLOCK_LOCKOUT_EN enables the failed-attempt lockout with alarm.
package padlock_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      ENTRY    = 2'd0,
      UNLOCKED = 2'd1,
      LOCKOUT  = 2'd2
   } state_e;

   // Digit k of a packed code (digit 0 in the low nibble); up to 8 digits.
   function automatic logic [DIGIT_W-1:0] code_digit(input logic [8*DIGIT_W-1:0] code,
                                                      input logic [3:0]           idx);
      code_digit = '0;
      for (int k = 0; k < 8; k++) begin
         if (idx == 4'(k)) code_digit = code[k*DIGIT_W +: DIGIT_W];
      end
   endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detection for the digit buttons and the open request.
// Edges are suppressed for the first cycle after reset so that inputs held
// high through reset release never register as a press or request.
module button_edge_detect #(
   parameter int NUM_BUTTONS = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] buttons,
   input  logic                   open,
   output logic                   press_valid,
   output logic                   press_multi,
   output logic [3:0]             press_idx,
   output logic                   open_req
);

   logic [NUM_BUTTONS-1:0] prev_buttons_q, prev_buttons_d;
   logic                   prev_open_q, prev_open_d;
   logic                   armed_q, armed_d;
   logic [NUM_BUTTONS-1:0] rise;

   // Next values of the history registers.
   always_comb begin
      prev_buttons_d = buttons;
      prev_open_d    = open;
      armed_d        = 1'b1;
   end

   // History registers; cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_buttons_q <= '0;
         prev_open_q    <= 1'b0;
         armed_q        <= 1'b0;
      end else begin
         prev_buttons_q <= prev_buttons_d;
         prev_open_q    <= prev_open_d;
         armed_q        <= armed_d;
      end
   end

   // Edge decode: any rise is a press, more than one rise marks it invalid,
   // the index reports the lowest rising button.
   always_comb begin
      rise        = armed_q ? (buttons & ~prev_buttons_q) : '0;
      press_valid = |rise;
      press_multi = (rise & (rise - 1'b1)) != '0;
      press_idx   = '0;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         if (rise[i]) press_idx = 4'(i);
      end
      open_req    = armed_q && open && !prev_open_q;
   end

endmodule

// File: rtl/code_padlock.sv
// Sequential code lock: digits are entered one press at a time, then an open
// request either unlocks for OPEN_CYCLES or counts as a failed attempt.
// Build option: PADLOCK_LOCKOUT_EN adds the tries counter, LOCKOUT state and
// alarm; without it a failure only clears the entry and alarm stays 0.
module code_padlock
   import padlock_pkg::*;
#(
   parameter int                      NUM_BUTTONS    = 10,
   parameter int                      CODE_LEN       = 4,
   parameter logic [4*CODE_LEN-1:0]   CODE           = 16'h9426,
   parameter int                      MAX_TRIES      = 3,
   parameter int                      OPEN_CYCLES    = 500,
   parameter int                      LOCKOUT_CYCLES = 1000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] buttons,
   input  logic                   open,
   output logic                   lock,
   output logic                   alarm,
   output logic [3:0]             digit_count
);

   localparam int TIMER_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
   localparam logic [3:0]  FULL_CNT = 4'(CODE_LEN);
   localparam logic [3:0]  SAT_CNT  = 4'(CODE_LEN + 1);
   localparam logic [31:0] CODE_EXT = 32'(CODE);

   logic       press_valid, press_multi, open_req;
   logic [3:0] press_idx;

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [3:0]           count_q, count_d;
   logic                 mismatch_q, mismatch_d;
   logic                 lock_q, lock_d;
`ifdef PADLOCK_LOCKOUT_EN
   localparam int TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
   logic [TRIES_W-1:0]   tries_q, tries_d;
   logic                 alarm_q, alarm_d;
`endif

   button_edge_detect #(.NUM_BUTTONS(NUM_BUTTONS)) u_edge (
      .clk         (clk),
      .rst         (reset),
      .buttons     (buttons),
      .open        (open),
      .press_valid (press_valid),
      .press_multi (press_multi),
      .press_idx   (press_idx),
      .open_req    (open_req)
   );

   // Next-state logic: entry accumulation, request evaluation, timed states.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      count_d    = count_q;
      mismatch_d = mismatch_q;
`ifdef PADLOCK_LOCKOUT_EN
      tries_d    = tries_q;
`endif
      case (state_q)
         ENTRY: begin
            // A request wins over a simultaneous press and sees the pre-press entry.
            if (open_req) begin
               count_d    = '0;
               mismatch_d = 1'b0;
               if (count_q == FULL_CNT && !mismatch_q) begin
                  state_d = UNLOCKED;
                  timer_d = TIMER_W'(OPEN_CYCLES);
`ifdef PADLOCK_LOCKOUT_EN
                  tries_d = '0;
`endif
               end else begin
`ifdef PADLOCK_LOCKOUT_EN
                  if (tries_q == LAST_TRY) begin
                     state_d = LOCKOUT;
                     timer_d = TIMER_W'(LOCKOUT_CYCLES);
                     tries_d = '0;
                  end else begin
                     tries_d = tries_q + 1'b1;
                  end
`endif
               end
            end else if (press_valid) begin
               // Wrong digits are only remembered; nothing visible changes until the request.
               if (press_multi || count_q >= FULL_CNT ||
                   press_idx != code_digit(CODE_EXT, count_q)) begin
                  mismatch_d = 1'b1;
               end
               if (count_q != SAT_CNT) count_d = count_q + 4'd1;
            end
         end
         UNLOCKED: begin
            timer_d    = timer_q - 1'b1;
            count_d    = '0;
            mismatch_d = 1'b0;
            if (timer_q == TIMER_W'(1)) state_d = ENTRY;
         end
`ifdef PADLOCK_LOCKOUT_EN
         LOCKOUT: begin
            timer_d    = timer_q - 1'b1;
            count_d    = '0;
            mismatch_d = 1'b0;
            if (timer_q == TIMER_W'(1)) state_d = ENTRY;
         end
`endif
         default: begin
            state_d    = ENTRY;
            count_d    = '0;
            mismatch_d = 1'b0;
         end
      endcase
      lock_d  = (state_d != UNLOCKED);
`ifdef PADLOCK_LOCKOUT_EN
      alarm_d = (state_d == LOCKOUT);
`endif
   end

   // State and registered outputs; reset returns to a locked, cleared entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ENTRY;
         timer_q    <= '0;
         count_q    <= '0;
         mismatch_q <= 1'b0;
         lock_q     <= 1'b1;
`ifdef PADLOCK_LOCKOUT_EN
         tries_q    <= '0;
         alarm_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         count_q    <= count_d;
         mismatch_q <= mismatch_d;
         lock_q     <= lock_d;
`ifdef PADLOCK_LOCKOUT_EN
         tries_q    <= tries_d;
         alarm_q    <= alarm_d;
`endif
      end
   end

   assign lock        = lock_q;
   assign digit_count = count_q;
`ifdef PADLOCK_LOCKOUT_EN
   assign alarm       = alarm_q;
`else
   assign alarm       = 1'b0;
`endif

endmodule

// File: tb/tb_code_padlock.sv
// Bench for code_padlock: directed button/open sequences push the expected
// output changes {duration, lock, alarm, digit_count} into a queue; a monitor
// pops one entry on every observed change of the outputs.
module tb_code_padlock;

   localparam int NB     = 10;
   localparam int OPEN_C = 500;
   localparam int LOCK_C = 1000;
   localparam int W      = 22;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NB-1:0] buttons = '0;
   logic          open_i = 1'b0;
   logic          lock, alarm;
   logic [3:0]    digit_count;

   logic [W-1:0]  exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            last_chg = 0;
   logic [5:0]    prev_obs = 6'b100000;
   bit            mon_en = 1'b0;
   bit            alarm_seen = 1'b0;

   // Clock
   always #5 clk = ~clk;

   code_padlock #(
      .NUM_BUTTONS    (NB),
      .CODE_LEN       (4),
      .CODE           (16'h9426),
      .MAX_TRIES      (3),
      .OPEN_CYCLES    (OPEN_C),
      .LOCKOUT_CYCLES (LOCK_C)
   ) dut (
      .clk         (clk),
      .reset       (rst),
      .buttons     (buttons),
      .open        (open_i),
      .lock        (lock),
      .alarm       (alarm),
      .digit_count (digit_count)
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: on each change of {lock, alarm, digit_count} pop and compare.
   always @(negedge clk) begin
      logic [5:0]   obs;
      logic [W-1:0] e;
      cyc++;
      obs = {lock, alarm, digit_count};
      if (alarm) alarm_seen = 1'b1;
      if (mon_en && obs != prev_obs) begin
         if (exp_q.size() == 0) begin
            check("unexpected_change", int'(obs), int'(prev_obs));
         end else begin
            e = exp_q.pop_front();
            check("outputs{lock,alarm,cnt}", int'(obs), int'(e[5:0]));
            if (e[21:6] != 16'd0) check("hold_cycles", cyc - last_chg, int'(e[21:6]));
         end
         prev_obs = obs;
         last_chg = cyc;
      end
   end

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int dur, input bit lk, input bit al, input int dc);
      exp_q.push_back({16'(dur), lk, al, 4'(dc)});
   endtask

   task automatic press(input int idx, input int dc_after, input bit changes);
      if (changes) push(0, 1'b1, 1'b0, dc_after);
      buttons = '0;
      buttons[idx] = 1'b1;
      tick(1);
      buttons = '0;
      tick(1);
   endtask

   task automatic press2(input int a, input int b, input int dc_after);
      push(0, 1'b1, 1'b0, dc_after);
      buttons = '0;
      buttons[a] = 1'b1;
      buttons[b] = 1'b1;
      tick(1);
      buttons = '0;
      tick(1);
   endtask

   task automatic request();
      open_i = 1'b1;
      tick(1);
      open_i = 1'b0;
      tick(1);
   endtask

   task automatic enter4(input int d0, input int d1, input int d2, input int d3);
      press(d0, 1, 1'b1);
      press(d1, 2, 1'b1);
      press(d2, 3, 1'b1);
      press(d3, 4, 1'b1);
   endtask

   task automatic fail_1234(input bit to_lockout);
      enter4(1, 2, 3, 4);
      push(0, 1'b1, to_lockout, 0);
      request();
      tick(2);
   endtask

   task automatic success_cycle();
      enter4(6, 2, 4, 9);
      push(0, 1'b0, 1'b0, 0);
      push(OPEN_C, 1'b1, 1'b0, 0);
      request();
      tick(OPEN_C + 10);
   endtask

   // Asynchronous reset mid-cycle with a button and open held across release.
   task automatic async_reset_hold();
      push(0, 1'b1, 1'b0, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_lock", int'(lock), 1);
      check("async_alarm", int'(alarm), 0);
      check("async_cnt", int'(digit_count), 0);
      buttons[6] = 1'b1;
      open_i = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(3);
      buttons = '0;
      open_i = 1'b0;
      tick(3);
   endtask

   initial begin
      // Power-on reset
      #1 rst = 1'b1;
      #1;
      check("reset_lock", int'(lock), 1);
      check("reset_alarm", int'(alarm), 0);
      check("reset_cnt", int'(digit_count), 0);
      tick(2);
      rst = 1'b0;
      mon_en = 1'b1;
      tick(2);

      // Correct code: unlock for exactly OPEN_C cycles
      success_cycle();

      // Wrong last digit
      enter4(6, 2, 4, 8);
      push(0, 1'b1, 1'b0, 0);
      request();
      tick(3);

      // Overflow: fifth digit, then a sixth that saturates the count
      enter4(6, 2, 4, 9);
      press(9, 5, 1'b1);
      press(9, 5, 1'b0);
      push(0, 1'b1, 1'b0, 0);
      request();
      tick(3);

      // open held 20 cycles gives one success; presses while unlocked ignored
      enter4(6, 2, 4, 9);
      push(0, 1'b0, 1'b0, 0);
      push(OPEN_C, 1'b1, 1'b0, 0);
      open_i = 1'b1;
      tick(20);
      open_i = 1'b0;
      tick(5);
      press(6, 0, 1'b0);
      press(2, 0, 1'b0);
      tick(OPEN_C);

      // Two buttons at once on digit 0 is an invalid digit
      press2(6, 2, 1);
      press(2, 2, 1'b1);
      press(4, 3, 1'b1);
      press(9, 4, 1'b1);
      push(0, 1'b1, 1'b0, 0);
      request();
      tick(3);

      // Two more failures: the third consecutive one starts lockout when enabled
      fail_1234(1'b0);
`ifdef PADLOCK_LOCKOUT_EN
      fail_1234(1'b1);
      push(LOCK_C, 1'b1, 1'b0, 0);
      press(6, 0, 1'b0);
      press(2, 0, 1'b0);
      press(4, 0, 1'b0);
      press(9, 0, 1'b0);
      request();
      tick(LOCK_C + 10);
`else
      fail_1234(1'b0);
      success_cycle();
`endif

      // Reset in the middle of UNLOCKED, then a fresh success
      enter4(6, 2, 4, 9);
      push(0, 1'b0, 1'b0, 0);
      request();
      tick(100);
      async_reset_hold();
      success_cycle();

`ifdef PADLOCK_LOCKOUT_EN
      // Reset in the middle of LOCKOUT, then a fresh success
      fail_1234(1'b0);
      fail_1234(1'b0);
      fail_1234(1'b1);
      tick(100);
      async_reset_hold();
      success_cycle();
`else
      // Five failures in a row never raise the alarm
      for (int i = 0; i < 5; i++) fail_1234(1'b0);
`endif

      // Request and press in the same cycle: request sees the pre-press entry
      enter4(6, 2, 4, 9);
      push(0, 1'b0, 1'b0, 0);
      push(OPEN_C, 1'b1, 1'b0, 0);
      open_i = 1'b1;
      buttons[9] = 1'b1;
      tick(1);
      open_i = 1'b0;
      buttons = '0;
      tick(OPEN_C + 10);

`ifndef PADLOCK_LOCKOUT_EN
      check("alarm_never_set", int'(alarm_seen), 0);
`endif
      tick(5);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
